// File: rtl/addr_gen_wr_hc.sv
// Write-side address generator for the H and C state memories.
// Zero-fills the t=-1 slot (addresses 0..NUM_CELL-1), then writes each
// accepted h/c pair for timestep t, cell k at address NUM_CELL*(t+1)+k.
module addr_gen_wr_hc #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_h,
    input  logic [DATA_WIDTH-1:0] i_c,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_we,
    output logic [DATA_WIDTH-1:0] o_data_h,
    output logic [DATA_WIDTH-1:0] o_data_c,
    output logic [ADDR_WIDTH-1:0] o_timestep,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(NUM_CELL - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CELL * (TIMESTEP + 1) - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_PTR = ADDR_WIDTH'(NUM_CELL);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    // cell_cnt = ptr mod NUM_CELL, ts_cnt = ptr/NUM_CELL - 1, kept as counters
    logic [ADDR_WIDTH-1:0] cell_cnt;
    logic [ADDR_WIDTH-1:0] ts_cnt;

    // Frame sequencing FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            o_addr     <= '0;
            o_we       <= 1'b0;
            o_data_h   <= '0;
            o_data_c   <= '0;
            o_timestep <= '0;
            o_ready    <= 1'b0;
            o_done     <= 1'b0;
            ptr        <= '0;
            cell_cnt   <= '0;
            ts_cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_we <= 1'b0;
                    if (start) begin
                        state    <= INIT;
                        o_addr   <= '0;
                        o_we     <= 1'b1;
                        o_data_h <= '0;
                        o_data_c <= '0;
                        o_done   <= 1'b0;
                    end
                end
                INIT: begin
                    if (o_addr == INIT_LAST) begin
                        state      <= RUN;
                        o_we       <= 1'b0;
                        o_ready    <= 1'b1;
                        ptr        <= FIRST_PTR;
                        cell_cnt   <= '0;
                        ts_cnt     <= '0;
                        o_timestep <= '0;
                    end else begin
                        o_addr   <= o_addr + 1'b1;
                        o_we     <= 1'b1;
                        o_data_h <= '0;
                        o_data_c <= '0;
                    end
                end
                RUN: begin
                    if (i_valid && o_ready) begin
                        o_addr     <= ptr;
                        o_we       <= 1'b1;
                        o_data_h   <= i_h;
                        o_data_c   <= i_c;
                        o_timestep <= ts_cnt;
                        ptr        <= ptr + 1'b1;
                        if (cell_cnt == INIT_LAST) begin
                            cell_cnt <= '0;
                            ts_cnt   <= ts_cnt + 1'b1;
                        end else begin
                            cell_cnt <= cell_cnt + 1'b1;
                        end
                        if (ptr == LAST_ADDR) begin
                            state   <= DONE;
                            o_ready <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end else begin
                        o_we <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_we    <= 1'b0;
                    o_ready <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_gen_wr_hc.sv
// Self-checking bench for addr_gen_wr_hc: a per-cycle behavioural model
// plus directed literal expectations.
module tb_addr_gen_wr_hc;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int TS = 7;
    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_h = '0;
    logic [DW-1:0] i_c = '0;
    logic          o_ready;
    logic [AW-1:0] o_addr;
    logic          o_we;
    logic [DW-1:0] o_data_h;
    logic [DW-1:0] o_data_c;
    logic [AW-1:0] o_timestep;
    logic          o_done;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    addr_gen_wr_hc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMESTEP(TS), .NUM_CELL(NC)) dut (
        .clk(clk), .rst(rst), .start(start), .i_valid(i_valid), .i_h(i_h), .i_c(i_c),
        .o_ready(o_ready), .o_addr(o_addr), .o_we(o_we), .o_data_h(o_data_h),
        .o_data_c(o_data_c), .o_timestep(o_timestep), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 zero-fill, 2 streaming, 3 finished
    int phase = 0;
    int zidx = 0;
    int nacc = 0;
    int e_addr = 0, e_we = 0, e_h = 0, e_c = 0, e_ts = 0, e_ready = 0, e_done = 0;

    always @(posedge clk) begin
        if (rst) begin
            phase = 0; zidx = 0; nacc = 0;
            e_addr = 0; e_we = 0; e_h = 0; e_c = 0; e_ts = 0; e_ready = 0; e_done = 0;
        end else if (phase == 0 || phase == 3) begin
            e_we = 0;
            if (start) begin
                phase = 1; zidx = 0;
                e_addr = 0; e_we = 1; e_h = 0; e_c = 0; e_done = 0;
            end
        end else if (phase == 1) begin
            if (zidx == NC - 1) begin
                phase = 2; nacc = 0;
                e_we = 0; e_ready = 1; e_ts = 0;
            end else begin
                zidx++;
                e_addr = zidx; e_we = 1; e_h = 0; e_c = 0;
            end
        end else begin
            if (i_valid) begin
                e_addr = NC + nacc;
                e_we = 1;
                e_h = int'(i_h);
                e_c = int'(i_c);
                e_ts = nacc / NC;
                nacc++;
                if (nacc == NC * TS) begin
                    phase = 3; e_ready = 0; e_done = 1;
                end
            end else begin
                e_we = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_we", 32'(o_we), 32'(e_we));
            chk("m_ready", 32'(o_ready), 32'(e_ready));
            chk("m_done", 32'(o_done), 32'(e_done));
            chk("m_ts", 32'(o_timestep), 32'(e_ts));
            if (e_we != 0) begin
                chk("m_addr", 32'(o_addr), 32'(e_addr));
                chk("m_h", 32'(o_data_h), 32'(e_h));
                chk("m_c", 32'(o_data_c), 32'(e_c));
            end
        end
    end

    int sample = 0;

    task automatic step(input logic s, input logic v);
        start = s;
        i_valid = v;
        i_h = DW'(16'h0101 + sample);
        i_c = DW'(16'h0202 + sample);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic accept();
        step(1'b0, 1'b1);
        sample++;
    endtask

    task automatic start_and_init();
        step(1'b1, 1'b0);
        chk("init_we0", 32'(o_we), 32'd1);
        chk("init_addr0", 32'(o_addr), 32'd0);
        chk("init_done0", 32'(o_done), 32'd0);
        for (int i = 1; i < NC; i++) begin
            step(1'b0, 1'b1);
            chk("init_addr", 32'(o_addr), 32'(i));
            chk("init_data", 32'(o_data_h), 32'd0);
        end
        step(1'b0, 1'b0);
        chk("run_we", 32'(o_we), 32'd0);
        chk("run_ready", 32'(o_ready), 32'd1);
        chk("run_done", 32'(o_done), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        step(1'b0, 1'b1);
        chk("idle_we", 32'(o_we), 32'd0);

        // Frame A: init, samples with gaps, start ignored, then reset mid-run
        start_and_init();
        accept();
        chk("s0_addr", 32'(o_addr), 32'd8);
        chk("s0_we", 32'(o_we), 32'd1);
        chk("s0_h", 32'(o_data_h), 32'h0101);
        chk("s0_c", 32'(o_data_c), 32'h0202);
        chk("s0_ts", 32'(o_timestep), 32'd0);
        for (int i = 1; i < 8; i++) accept();
        chk("s7_addr", 32'(o_addr), 32'd15);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("gap_we", 32'(o_we), 32'd0);
        end
        accept();
        chk("s8_addr", 32'(o_addr), 32'd16);
        chk("s8_ts", 32'(o_timestep), 32'd1);
        step(1'b1, 1'b0);
        chk("run_start_we", 32'(o_we), 32'd0);
        chk("run_start_ready", 32'(o_ready), 32'd1);
        accept();
        chk("s9_addr", 32'(o_addr), 32'd17);
        while (sample < 20) accept();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk("mrst_addr", 32'(o_addr), 32'd0);
        chk("mrst_we", 32'(o_we), 32'd0);
        chk("mrst_ready", 32'(o_ready), 32'd0);
        chk("mrst_ts", 32'(o_timestep), 32'd0);
        chk("mrst_h", 32'(o_data_h), 32'd0);
        step(1'b0, 1'b1);
        chk("mrst_idle_we", 32'(o_we), 32'd0);

        // Frame B: full frame with periodic gaps
        sample = 0;
        start_and_init();
        while (sample < NC * TS) begin
            accept();
            if (sample % 5 == 0) step(1'b0, 1'b0);
        end
        if (sample % 5 != 0) begin
            chk("last_addr", 32'(o_addr), 32'd63);
            chk("last_ts", 32'(o_timestep), 32'd6);
            chk("last_we", 32'(o_we), 32'd1);
            step(1'b0, 1'b0);
        end
        chk("done_ready", 32'(o_ready), 32'd0);
        chk("done_done", 32'(o_done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("done_valid_we", 32'(o_we), 32'd0);
            chk("done_hold", 32'(o_done), 32'd1);
        end

        // Restart from DONE
        start_and_init();
        accept();
        chk("rs_addr", 32'(o_addr), 32'd8);
        chk("rs_ts", 32'(o_timestep), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
